aho_table_writer: RTL and testbench

Loads the Aho-Corasick goto and failure tables that the table reader scans during matching. Accepts table entries from a host or config loader over a valid/ready command stream. Emits registered write strobes into the goto RAMs (current state, character, next state) and the failure RAM. Tracks the number of valid goto entries and flags when a complete table is available to the matcher.

---
 rtl/aho_table_writer_if.sv | 23 ++
 rtl/aho_table_writer.sv | 204 ++++++++++++++++++++
 tb/tb_aho_table_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aho_table_writer_if.sv
// Command stream into the Aho-Corasick table writer: valid/ready handshake plus opcode and operands.
// The host/loader side uses the master modport; the writer uses the slave modport.
interface aho_table_writer_if #(
  parameter int STATE_W = 8,
  parameter int CHARA_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [STATE_W-1:0] cmd_state;
  logic [CHARA_W-1:0] cmd_chara;
  logic [STATE_W-1:0] cmd_next;

  modport master (
    output cmd_valid, cmd_op, cmd_state, cmd_chara, cmd_next,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_state, cmd_chara, cmd_next,
    output cmd_ready
  );
endinterface

// File: rtl/aho_table_writer.sv
// Loads Aho-Corasick goto/failure tables from a command stream as registered one-cycle RAM writes.
// Optional zero-fill sweep on START is enabled by defining AHO_TABLE_WRITER_CLEAR_EN.
module aho_table_writer #(
  parameter int DEPTH   = 32,
  parameter int STATE_W = 8,
  parameter int CHARA_W = 4,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  aho_table_writer_if.slave  cmd,
  output logic               goto_we_o,
  output logic [ADDR_W-1:0]  goto_addr_o,
  output logic [STATE_W-1:0] goto_cur_o,
  output logic [CHARA_W-1:0] goto_chara_o,
  output logic [STATE_W-1:0] goto_next_o,
  output logic               fail_we_o,
  output logic [ADDR_W-1:0]  fail_addr_o,
  output logic [STATE_W-1:0] fail_data_o,
  output logic [ADDR_W:0]    goto_count_o,
  output logic               table_valid_o,
  output logic               error_o
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_GOTO  = 2'b01;
  localparam logic [1:0] OP_FAIL  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               goto_we_q, goto_we_d;
  logic [ADDR_W-1:0]  goto_addr_q, goto_addr_d;
  logic [STATE_W-1:0] goto_cur_q, goto_cur_d;
  logic [CHARA_W-1:0] goto_chara_q, goto_chara_d;
  logic [STATE_W-1:0] goto_next_q, goto_next_d;
  logic               fail_we_q, fail_we_d;
  logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
  logic [STATE_W-1:0] fail_data_q, fail_data_d;
  logic               cmd_ready;
  logic               accept;
  logic               fail_in_range;

`ifdef AHO_TABLE_WRITER_CLEAR_EN
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
`endif

  assign cmd_ready     = (state_q != S_CLEAR);
  assign cmd.cmd_ready = cmd_ready;
  assign accept        = cmd.cmd_valid && cmd_ready;
  assign fail_in_range = (cmd.cmd_state != '0) && (cmd.cmd_state <= STATE_W'(DEPTH));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    valid_d      = valid_q;
    error_d      = error_q;
    goto_we_d    = 1'b0;
    goto_addr_d  = goto_addr_q;
    goto_cur_d   = goto_cur_q;
    goto_chara_d = goto_chara_q;
    goto_next_d  = goto_next_q;
    fail_we_d    = 1'b0;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
`ifdef AHO_TABLE_WRITER_CLEAR_EN
    clr_addr_d   = clr_addr_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin
              valid_d = 1'b0;
              error_d = 1'b0;
              count_d = '0;
`ifdef AHO_TABLE_WRITER_CLEAR_EN
              // Address 0 is written on the START edge itself so the sweep ends DEPTH cycles later.
              state_d      = S_CLEAR;
              goto_we_d    = 1'b1;
              fail_we_d    = 1'b1;
              goto_addr_d  = '0;
              fail_addr_d  = '0;
              goto_cur_d   = '0;
              goto_chara_d = '0;
              goto_next_d  = '0;
              fail_data_d  = '0;
              clr_addr_d   = ADDR_W'(1);
`else
              state_d = S_LOAD;
`endif
            end
            OP_GOTO: begin
              if (state_q == S_LOAD && count_q < (ADDR_W+1)'(DEPTH)) begin
                goto_we_d    = 1'b1;
                goto_addr_d  = count_q[ADDR_W-1:0];
                goto_cur_d   = cmd.cmd_state;
                goto_chara_d = cmd.cmd_chara;
                goto_next_d  = cmd.cmd_next;
                count_d      = count_q + (ADDR_W+1)'(1);
              end else begin
                error_d = 1'b1;
              end
            end
            OP_FAIL: begin
              if (state_q == S_LOAD && fail_in_range) begin
                fail_we_d   = 1'b1;
                fail_addr_d = ADDR_W'(cmd.cmd_state - STATE_W'(1));
                fail_data_d = cmd.cmd_next;
              end else begin
                error_d = 1'b1;
              end
            end
            default: begin
              if (state_q == S_LOAD) begin
                valid_d = 1'b1;
                state_d = S_IDLE;
              end else begin
                error_d = 1'b1;
              end
            end
          endcase
        end
      end
`ifdef AHO_TABLE_WRITER_CLEAR_EN
      S_CLEAR: begin
        // Address wraps to 0 once DEPTH-1 is written; that cycle hands over to LOAD.
        if (clr_addr_q == '0) begin
          state_d = S_LOAD;
        end else begin
          goto_we_d    = 1'b1;
          fail_we_d    = 1'b1;
          goto_addr_d  = clr_addr_q;
          fail_addr_d  = clr_addr_q;
          goto_cur_d   = '0;
          goto_chara_d = '0;
          goto_next_d  = '0;
          fail_data_d  = '0;
          clr_addr_d   = clr_addr_q + ADDR_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      goto_we_q    <= 1'b0;
      goto_addr_q  <= '0;
      goto_cur_q   <= '0;
      goto_chara_q <= '0;
      goto_next_q  <= '0;
      fail_we_q    <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      goto_we_q    <= goto_we_d;
      goto_addr_q  <= goto_addr_d;
      goto_cur_q   <= goto_cur_d;
      goto_chara_q <= goto_chara_d;
      goto_next_q  <= goto_next_d;
      fail_we_q    <= fail_we_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
    end
  end

`ifdef AHO_TABLE_WRITER_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_addr_q <= '0;
    else     clr_addr_q <= clr_addr_d;
  end
`endif

  assign goto_we_o     = goto_we_q;
  assign goto_addr_o   = goto_addr_q;
  assign goto_cur_o    = goto_cur_q;
  assign goto_chara_o  = goto_chara_q;
  assign goto_next_o   = goto_next_q;
  assign fail_we_o     = fail_we_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_data_o   = fail_data_q;
  assign goto_count_o  = count_q;
  assign table_valid_o = valid_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_aho_table_writer.sv
// Scoreboard bench for aho_table_writer: directed table-load scenarios plus random command streams.
// Honours AHO_TABLE_WRITER_CLEAR_EN so the same bench covers both builds.
module tb_aho_table_writer;
  localparam int DEPTH   = 32;
  localparam int STATE_W = 8;
  localparam int CHARA_W = 4;
  localparam int ADDR_W  = 5;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_GOTO  = 2'b01;
  localparam logic [1:0] OP_FAIL  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aho_table_writer_if #(.STATE_W(STATE_W), .CHARA_W(CHARA_W)) cmd ();

  logic               goto_we, fail_we, table_valid, error;
  logic [ADDR_W-1:0]  goto_addr, fail_addr;
  logic [STATE_W-1:0] goto_cur, goto_next, fail_data;
  logic [CHARA_W-1:0] goto_chara;
  logic [ADDR_W:0]    goto_count;

  aho_table_writer #(.DEPTH(DEPTH), .STATE_W(STATE_W), .CHARA_W(CHARA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .goto_we_o(goto_we), .goto_addr_o(goto_addr), .goto_cur_o(goto_cur),
    .goto_chara_o(goto_chara), .goto_next_o(goto_next),
    .fail_we_o(fail_we), .fail_addr_o(fail_addr), .fail_data_o(fail_data),
    .goto_count_o(goto_count), .table_valid_o(table_valid), .error_o(error)
  );

  // Expected RAM writes: kind 0 = goto, 1 = failure, 2 = clear (both RAMs, zero data).
  typedef struct {
    int kind;
    int addr;
    int cur;
    int chara;
    int nxt;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model of the table-loading rules.
  bit  m_loading;
  int  m_count;
  bit  m_valid;
  bit  m_error;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (goto_we || fail_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: goto_we=%0b fail_we=%0b gaddr=%0d faddr=%0d, required no strobe (t=%0t)",
                 goto_we, fail_we, goto_addr, fail_addr, $time);
      end else begin
        wr_t e;
        bit  ok;
        e = exp_q.pop_front();
        case (e.kind)
          0: ok = goto_we && !fail_we && int'(goto_addr) == e.addr && int'(goto_cur) == e.cur &&
                  int'(goto_chara) == e.chara && int'(goto_next) == e.nxt;
          1: ok = fail_we && !goto_we && int'(fail_addr) == e.addr && int'(fail_data) == e.nxt;
          default: ok = goto_we && fail_we && int'(goto_addr) == e.addr && int'(fail_addr) == e.addr &&
                        goto_cur == '0 && goto_chara == '0 && goto_next == '0 && fail_data == '0;
        endcase
        if (!ok) begin
          errors++;
          $display("FAIL write_data: we=%0b/%0b gaddr=%0d cur=%0d ch=%0d nxt=%0d faddr=%0d fdata=%0d, required kind=%0d addr=%0d cur=%0d ch=%0d nxt=%0d (t=%0t)",
                   goto_we, fail_we, goto_addr, goto_cur, goto_chara, goto_next, fail_addr, fail_data,
                   e.kind, e.addr, e.cur, e.chara, e.nxt, $time);
        end
      end
    end
  end

  function automatic void model_cmd(input logic [1:0] op, input int st, input int ch, input int nx);
    case (op)
      OP_START: begin
        m_valid   = 1'b0;
        m_error   = 1'b0;
        m_count   = 0;
        m_loading = 1'b1;
`ifdef AHO_TABLE_WRITER_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) exp_q.push_back('{kind: 2, addr: a, cur: 0, chara: 0, nxt: 0});
`endif
      end
      OP_GOTO: begin
        if (m_loading && m_count < DEPTH) begin
          exp_q.push_back('{kind: 0, addr: m_count, cur: st, chara: ch, nxt: nx});
          m_count++;
        end else m_error = 1'b1;
      end
      OP_FAIL: begin
        if (m_loading && st >= 1 && st <= DEPTH)
          exp_q.push_back('{kind: 1, addr: st - 1, cur: 0, chara: 0, nxt: nx});
        else m_error = 1'b1;
      end
      default: begin
        if (m_loading) begin
          m_valid   = 1'b1;
          m_loading = 1'b0;
        end else m_error = 1'b1;
      end
    endcase
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".goto_count"}, int'(goto_count), m_count);
    chk({tag, ".table_valid"}, int'(table_valid), int'(m_valid));
    chk({tag, ".error"}, int'(error), int'(m_error));
  endtask

  // Drive one command from a negedge, wait (bounded) for ready, then check status after the accepting edge.
  task automatic send(input logic [1:0] op, input int st, input int ch, input int nx, input bit do_chk);
    int n = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_state = STATE_W'(st);
    cmd.cmd_chara = CHARA_W'(ch);
    cmd.cmd_next  = STATE_W'(nx);
    while (!cmd.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, required 1", n);
    end
    model_cmd(op, st, ch, nx);
    $display("cmd op=%0d state=%0d chara=%0d next=%0d", op, st, ch, nx);
    @(posedge clk);
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    if (do_chk) check_status("cmd");
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    idle(cycles);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".goto_count"}, int'(goto_count), 0);
    chk({tag, ".table_valid"}, int'(table_valid), 0);
    chk({tag, ".error"}, int'(error), 0);
    chk({tag, ".cmd_ready"}, int'(cmd.cmd_ready), 1);
    chk({tag, ".strobes"}, int'({goto_we, fail_we}), 0);
  endtask

  initial begin
    int op_sel;
    logic [1:0] op;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = '0;
    cmd.cmd_state = '0;
    cmd.cmd_chara = '0;
    cmd.cmd_next  = '0;
    m_loading = 0; m_count = 0; m_valid = 0; m_error = 0;

    idle(2);
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    // Basic load from the example table.
    send(OP_START, 0, 0, 0, 1);
    send(OP_GOTO, 0, 1, 1, 1);
    send(OP_GOTO, 1, 2, 2, 1);
    send(OP_FAIL, 2, 0, 1, 1);
    send(OP_END, 0, 0, 0, 1);
    drain(3);
`ifdef AHO_TABLE_WRITER_CLEAR_EN
    chk("clear_start_ready", int'(cmd.cmd_ready), 1);
`endif

    // Command in IDLE after END: error, table stays valid.
    send(OP_GOTO, 3, 4, 5, 1);
    send(OP_START, 0, 0, 0, 1);
    send(OP_GOTO, 7, 7, 7, 1);
    send(OP_START, 0, 0, 0, 1);

    // Saturation: 33 GOTOs leave 32 writes and raise the error flag.
    for (int i = 0; i < DEPTH + 1; i++) send(OP_GOTO, i, i % 16, i + 1, 1);
    drain(2);

    // Out-of-range failure states, then START clears the error.
    send(OP_START, 0, 0, 0, 1);
    send(OP_FAIL, 0, 0, 9, 1);
    send(OP_FAIL, DEPTH + 1, 0, 9, 1);
    send(OP_FAIL, DEPTH, 0, 9, 1);
    send(OP_FAIL, DEPTH, 0, 4, 1);
    send(OP_START, 0, 0, 0, 1);
    drain(2);

    // Asynchronous reset mid-load after three GOTOs.
    for (int i = 0; i < 3; i++) send(OP_GOTO, i, i, i + 1, 1);
    #2 rst = 1'b1;
    m_loading = 0; m_count = 0; m_valid = 0; m_error = 0;
    idle(1);
    check_reset_state("mid_load_reset");
    chk("pending_writes_reset", exp_q.size(), 0);
    rst = 1'b0;
    idle(1);

    // Randomised command stream against the model.
    for (int k = 0; k < 300; k++) begin
      op_sel = int'($urandom_range(0, 99));
      if (op_sel < 6)       op = OP_START;
      else if (op_sel < 55) op = OP_GOTO;
      else if (op_sel < 88) op = OP_FAIL;
      else                  op = OP_END;
      send(op, int'($urandom_range(0, 40)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    drain(DEPTH + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
